// File: rtl/mem_stage_pkg.sv
// Shared Y86-64 defines for the memory stage: icodes, status codes, register
// ids, FSM state encoding and the access classification helper.
package mem_stage_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RD_E = 2'd1,
        ACC_RD_A = 2'd2,
        ACC_WR_E = 2'd3
    } acc_kind_e;

    function automatic acc_kind_e access_kind(input logic [3:0] icode);
        acc_kind_e k;
        case (icode)
            IMRMOVQ:                k = ACC_RD_E;
            IPOPQ, IRET:            k = ACC_RD_A;
            IRMMOVQ, IPUSHQ, ICALL: k = ACC_WR_E;
            default:                k = ACC_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Handshake: req is held with we/addr/wdata stable until gnt is seen high on
// a clock edge; the access then completes on the first cycle rvalid is high,
// with err qualifying rvalid and rdata valid for reads only.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic            dmem_err_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_err_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_err_i, dmem_rdata_i
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Access sequencer for the memory stage: request/grant/response handshake,
// response timeout, and the busy/valid indications seen by the pipeline.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       capture_i,
    input  logic       start_i,
    input  logic       gnt_i,
    input  logic       rvalid_i,
    input  logic       err_i,
    output logic [1:0] state_o,
    output logic       req_o,
    output logic       busy_o,
    output logic       valid_o,
    output logic       rsp_o,
    output logic       fault_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          timeout;

    // A response is only honoured while an access is actually in flight.
    assign rsp_o   = ((state_q == ST_REQ) && gnt_i && rvalid_i) ||
                     ((state_q == ST_WAIT) && rvalid_i);
    assign timeout = (state_q == ST_WAIT) && !rvalid_i && (cnt_q == CW'(TIMEOUT - 1));
    assign fault_o = (rsp_o && err_i) || timeout;

    assign state_o = state_q;
    assign req_o   = (state_q == ST_REQ);
    assign busy_o  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign valid_o = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (capture_i) state_d = start_i ? ST_REQ : ST_DONE;
                else           state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (gnt_i) state_d = rvalid_i ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (rvalid_i || timeout) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_REQ)       cnt_q <= '0;
            else if (state_q == ST_WAIT) cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register, access classification and the
// m_* result bundle for writeback and forwarding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [3:0]      e_icode_i,
    input  logic [2:0]      e_stat_i,
    input  logic [XLEN-1:0] e_valE_i,
    input  logic [XLEN-1:0] e_valA_i,
    input  logic [3:0]      e_dstE_i,
    input  logic [3:0]      e_dstM_i,
    input  logic            e_Cnd_i,
    mem_stage_if.master     dmem,
    output logic [3:0]      m_icode_o,
    output logic [2:0]      m_stat_o,
    output logic [XLEN-1:0] m_valE_o,
    output logic [XLEN-1:0] m_valM_o,
    output logic [3:0]      m_dstE_o,
    output logic [3:0]      m_dstM_o,
    output logic            m_Cnd_o,
    output logic            m_valid_o,
    output logic            mem_busy_o,
    output logic [1:0]      dbg_state_o
);

    localparam logic [XLEN-1:0] ADDR_MAX = XLEN'(MEM_BYTES - 8);

    logic            capture, start, need_acc, addr_bad;
    logic [3:0]      n_icode;
    logic [2:0]      n_stat;
    logic [XLEN-1:0] n_addr;
    acc_kind_e       n_kind, kind_q;
    logic [XLEN-1:0] valA_q;
    logic            rsp, fault;

    assign capture = (load_i || bubble_i) && !mem_busy_o;
    assign n_icode = bubble_i ? INOP : e_icode_i;
    assign n_stat  = bubble_i ? SAOK : e_stat_i;
    assign n_kind  = access_kind(n_icode);
    assign n_addr  = (n_kind == ACC_RD_A) ? e_valA_i : e_valE_i;

    // Instructions already faulted upstream never touch memory.
    assign need_acc = (n_kind != ACC_NONE) && (n_stat == SAOK);
    assign addr_bad = n_addr > ADDR_MAX;
    assign start    = capture && need_acc && !addr_bad;

    mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (capture),
        .start_i   (start),
        .gnt_i     (dmem.dmem_gnt_i),
        .rvalid_i  (dmem.dmem_rvalid_i),
        .err_i     (dmem.dmem_err_i),
        .state_o   (dbg_state_o),
        .req_o     (dmem.dmem_req_o),
        .busy_o    (mem_busy_o),
        .valid_o   (m_valid_o),
        .rsp_o     (rsp),
        .fault_o   (fault)
    );

    // Request fields come straight from the M register, so they stay stable in REQ.
    assign dmem.dmem_we_o    = (kind_q == ACC_WR_E);
    assign dmem.dmem_addr_o  = (kind_q == ACC_RD_A) ? valA_q : m_valE_o;
    assign dmem.dmem_wdata_o = valA_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_icode_o <= INOP;
            m_stat_o  <= SAOK;
            m_valE_o  <= '0;
            valA_q    <= '0;
            m_dstE_o  <= RNONE;
            m_dstM_o  <= RNONE;
            m_Cnd_o   <= 1'b0;
            kind_q    <= ACC_NONE;
        end else if (capture) begin
            m_icode_o <= n_icode;
            m_stat_o  <= (need_acc && addr_bad) ? SADR : n_stat;
            m_valE_o  <= bubble_i ? '0 : e_valE_i;
            valA_q    <= bubble_i ? '0 : e_valA_i;
            m_dstE_o  <= bubble_i ? RNONE : e_dstE_i;
            m_dstM_o  <= bubble_i ? RNONE : e_dstM_i;
            m_Cnd_o   <= bubble_i ? 1'b0 : e_Cnd_i;
            kind_q    <= n_kind;
        end else if (fault) begin
            m_stat_o <= SADR;
        end
    end

    // Only a clean read response updates valM; stores and faults hold it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valM_o <= '0;
        end else if (rsp && !dmem.dmem_err_i && (kind_q != ACC_WR_E)) begin
            m_valM_o <= dmem.dmem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single-cycle captures plus
// hand-written sequences for handshake latency, faults, timeout and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MEM_BYTES = 8192;
  localparam int TIMEOUT   = 255;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_i = 1'b0, bubble_i = 1'b0;
  logic [3:0]  e_icode_i = INOP;
  logic [2:0]  e_stat_i = SAOK;
  logic [63:0] e_valE_i = '0, e_valA_i = '0;
  logic [3:0]  e_dstE_i = RNONE, e_dstM_i = RNONE;
  logic        e_Cnd_i = 1'b0;
  logic [3:0]  m_icode_o, m_dstE_o, m_dstM_o;
  logic [2:0]  m_stat_o;
  logic [63:0] m_valE_o, m_valM_o;
  logic        m_Cnd_o, m_valid_o, mem_busy_o;
  logic [1:0]  dbg_state_o;

  mem_stage_if dmem();

  mem_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .bubble_i(bubble_i),
    .e_icode_i(e_icode_i), .e_stat_i(e_stat_i), .e_valE_i(e_valE_i),
    .e_valA_i(e_valA_i), .e_dstE_i(e_dstE_i), .e_dstM_i(e_dstM_i),
    .e_Cnd_i(e_Cnd_i), .dmem(dmem.master),
    .m_icode_o(m_icode_o), .m_stat_o(m_stat_o), .m_valE_o(m_valE_o),
    .m_valM_o(m_valM_o), .m_dstE_o(m_dstE_o), .m_dstM_o(m_dstM_o),
    .m_Cnd_o(m_Cnd_o), .m_valid_o(m_valid_o), .mem_busy_o(mem_busy_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_valM = '0;

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        cnd;
    logic        bubble;
    logic [3:0]  x_icode;
    logic [2:0]  x_stat;
    logic [63:0] x_valE;
    logic [3:0]  x_dstE;
    logic [3:0]  x_dstM;
    logic        x_cnd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // driver tasks
  task automatic drive_e(input logic [3:0] icode, input logic [2:0] stat,
                         input logic [63:0] valE, input logic [63:0] valA,
                         input logic [3:0] dstE, input logic [3:0] dstM, input logic cnd);
    e_icode_i = icode; e_stat_i = stat; e_valE_i = valE; e_valA_i = valA;
    e_dstE_i = dstE; e_dstM_i = dstM; e_Cnd_i = cnd;
  endtask

  task automatic capture(input logic [3:0] icode, input logic [2:0] stat,
                         input logic [63:0] valE, input logic [63:0] valA,
                         input logic [3:0] dstE, input logic [3:0] dstM,
                         input logic cnd, input logic bub);
    drive_e(icode, stat, valE, valA, dstE, dstM, cnd);
    load_i = ~bub;
    bubble_i = bub;
    tick();
    load_i = 1'b0;
    bubble_i = 1'b0;
  endtask

  // Memory responder: n_req REQ cycles (gnt in the last), then n_wait WAIT
  // cycles (rvalid in the last; 0 means rvalid together with gnt). load_i is
  // held high with junk throughout to show captures are ignored while busy.
  task automatic run_access(input string tag, input int n_req, input int n_wait,
                            input logic err, input logic [63:0] rdata,
                            input logic x_we, input logic [63:0] x_addr,
                            input logic [63:0] x_wdata);
    int busy_n = 0;
    chk({tag, "_req"}, dmem.dmem_req_o, 1);
    chk({tag, "_we"}, dmem.dmem_we_o, x_we);
    chk({tag, "_addr"}, dmem.dmem_addr_o, x_addr);
    if (x_we) chk({tag, "_wdata"}, dmem.dmem_wdata_o, x_wdata);
    if (!x_we && !err) exp_q.push_back(rdata);
    drive_e(IOPQ, SAOK, 64'h999, 64'h999, 4'h1, 4'h1, 1'b1);
    load_i = 1'b1;
    for (int i = 0; i < n_req; i++) begin
      if (mem_busy_o) busy_n++;
      if (i == n_req - 1) begin
        dmem.dmem_gnt_i = 1'b1;
        if (n_wait == 0) begin
          dmem.dmem_rvalid_i = 1'b1; dmem.dmem_err_i = err; dmem.dmem_rdata_i = rdata;
        end
      end
      tick();
      dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_err_i = 1'b0;
    end
    for (int j = 0; j < n_wait; j++) begin
      if (mem_busy_o) busy_n++;
      if (j == 0) chk({tag, "_req_wait"}, dmem.dmem_req_o, 0);
      if (j == n_wait - 1) begin
        dmem.dmem_rvalid_i = 1'b1; dmem.dmem_err_i = err; dmem.dmem_rdata_i = rdata;
      end
      tick();
      dmem.dmem_rvalid_i = 1'b0; dmem.dmem_err_i = 1'b0;
    end
    load_i = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(n_req + n_wait));
    chk({tag, "_valid"}, m_valid_o, 1);
    chk({tag, "_busy_done"}, mem_busy_o, 0);
    if (exp_q.size() > 0) model_valM = exp_q.pop_front();
    if (!err) chk({tag, "_valM"}, m_valM_o, model_valM);
  endtask

  initial begin
    int w;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_err_i = 1'b0; dmem.dmem_rdata_i = '0;

    vecs[0] = '{IOPQ, SAOK, 64'h2A, 64'h7, 4'd3, RNONE, 1'b0, 1'b0, IOPQ, SAOK, 64'h2A, 4'd3, RNONE, 1'b0};
    vecs[1] = '{IOPQ, SINS, 64'h55, 64'h1, 4'd2, 4'd4, 1'b1, 1'b1, INOP, SAOK, 64'h0, RNONE, RNONE, 1'b0};
    vecs[2] = '{IPOPQ, SAOK, 64'h10, 64'(MEM_BYTES - 4), 4'd4, 4'd5, 1'b0, 1'b0, IPOPQ, SADR, 64'h10, 4'd4, 4'd5, 1'b0};
    vecs[3] = '{IRMMOVQ, SINS, 64'h100, 64'h9, RNONE, RNONE, 1'b0, 1'b0, IRMMOVQ, SINS, 64'h100, RNONE, RNONE, 1'b0};
    vecs[4] = '{IMRMOVQ, SAOK, 64'(MEM_BYTES - 7), 64'h0, RNONE, 4'd6, 1'b0, 1'b0, IMRMOVQ, SADR, 64'(MEM_BYTES - 7), RNONE, 4'd6, 1'b0};
    vecs[5] = '{IIRMOVQ, SAOK, 64'h1234, 64'h0, 4'd5, RNONE, 1'b0, 1'b0, IIRMOVQ, SAOK, 64'h1234, 4'd5, RNONE, 1'b0};
    vecs[6] = '{IJXX, SAOK, 64'h0, 64'h44, RNONE, RNONE, 1'b1, 1'b0, IJXX, SAOK, 64'h0, RNONE, RNONE, 1'b1};
    vecs[7] = '{IHALT, SHLT, 64'h0, 64'h0, RNONE, RNONE, 1'b0, 1'b0, IHALT, SHLT, 64'h0, RNONE, RNONE, 1'b0};
    vecs[8] = '{ICALL, SAOK, 64'hFFFF_FFFF_FFFF_FFF8, 64'h33, RNONE, RNONE, 1'b0, 1'b0, ICALL, SADR, 64'hFFFF_FFFF_FFFF_FFF8, RNONE, RNONE, 1'b0};

    // reset state
    tick(); tick();
    chk("rst_icode", m_icode_o, INOP);
    chk("rst_stat", m_stat_o, SAOK);
    chk("rst_dstE", m_dstE_o, RNONE);
    chk("rst_valM", m_valM_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", mem_busy_o, 0);
    chk("rst_req", dmem.dmem_req_o, 0);
    chk("rst_state", dbg_state_o, ST_IDLE);
    rst_i = 1'b0;
    tick();

    // single-cycle captures: pass-through, bubble and fault/no-access cases
    foreach (vecs[k]) begin
      capture(vecs[k].icode, vecs[k].stat, vecs[k].valE, vecs[k].valA,
              vecs[k].dstE, vecs[k].dstM, vecs[k].cnd, vecs[k].bubble);
      chk($sformatf("v%0d_valid", k), m_valid_o, 1);
      chk($sformatf("v%0d_busy", k), mem_busy_o, 0);
      chk($sformatf("v%0d_req", k), dmem.dmem_req_o, 0);
      chk($sformatf("v%0d_icode", k), m_icode_o, vecs[k].x_icode);
      chk($sformatf("v%0d_stat", k), m_stat_o, vecs[k].x_stat);
      chk($sformatf("v%0d_valE", k), m_valE_o, vecs[k].x_valE);
      chk($sformatf("v%0d_dstE", k), m_dstE_o, vecs[k].x_dstE);
      chk($sformatf("v%0d_dstM", k), m_dstM_o, vecs[k].x_dstM);
      chk($sformatf("v%0d_cnd", k), m_Cnd_o, vecs[k].x_cnd);
    end
    tick();
    chk("done_one_cycle", m_valid_o, 0);

    // load with grant after 2 cycles and response 3 cycles later
    capture(IMRMOVQ, SAOK, 64'h100, 64'h0, RNONE, 4'd2, 1'b0, 1'b0);
    run_access("load", 2, 3, 1'b0, 64'hDEAD_BEEF, 1'b0, 64'h100, 64'h0);
    chk("load_stat", m_stat_o, SAOK);
    chk("load_icode_held", m_icode_o, IMRMOVQ);
    chk("load_valE_held", m_valE_o, 64'h100);
    tick();

    // push: grant and response in the same cycle, valM untouched
    capture(IPUSHQ, SAOK, 64'h1F0, 64'h55, 4'd4, RNONE, 1'b0, 1'b0);
    run_access("push", 1, 0, 1'b0, 64'h1111, 1'b1, 64'h1F0, 64'h55);
    chk("push_stat", m_stat_o, SAOK);
    tick();

    // popq reads at valA
    capture(IPOPQ, SAOK, 64'h208, 64'h200, 4'd4, 4'd1, 1'b0, 1'b0);
    run_access("pop", 2, 1, 1'b0, 64'hCAFE, 1'b0, 64'h200, 64'h0);
    tick();

    // highest legal address
    capture(IMRMOVQ, SAOK, 64'(MEM_BYTES - 8), 64'h0, RNONE, 4'd3, 1'b0, 1'b0);
    run_access("edge", 1, 0, 1'b0, 64'h1122, 1'b0, 64'(MEM_BYTES - 8), 64'h0);
    chk("edge_stat", m_stat_o, SAOK);
    tick();

    // error response
    capture(IMRMOVQ, SAOK, 64'h80, 64'h0, RNONE, 4'd3, 1'b0, 1'b0);
    run_access("err", 1, 2, 1'b1, 64'h5A5A, 1'b0, 64'h80, 64'h0);
    chk("err_stat", m_stat_o, SADR);
    tick();

    // timeout: no response ever arrives
    capture(IMRMOVQ, SAOK, 64'h88, 64'h0, RNONE, 4'd3, 1'b0, 1'b0);
    dmem.dmem_gnt_i = 1'b1;
    tick();
    dmem.dmem_gnt_i = 1'b0;
    w = 0;
    while (mem_busy_o && w < 1000) begin
      w++;
      tick();
    end
    chk("to_wait_cycles", 64'(w), 64'(TIMEOUT));
    chk("to_valid", m_valid_o, 1);
    chk("to_stat", m_stat_o, SADR);
    chk("to_valM_held", m_valM_o, model_valM);
    tick();

    // reset in WAIT, then a stale response after release
    capture(IMRMOVQ, SAOK, 64'h40, 64'h0, RNONE, 4'd3, 1'b0, 1'b0);
    dmem.dmem_gnt_i = 1'b1;
    tick();
    dmem.dmem_gnt_i = 1'b0;
    tick();
    chk("mid_busy_pre", mem_busy_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_req_async", dmem.dmem_req_o, 0);
    chk("mid_busy_async", mem_busy_o, 0);
    tick();
    rst_i = 1'b0;
    dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 64'hBAD;
    tick();
    dmem.dmem_rvalid_i = 1'b0;
    tick();
    chk("stale_valM", m_valM_o, 0);
    chk("stale_valid", m_valid_o, 0);
    chk("stale_state", dbg_state_o, ST_IDLE);
    chk("stale_icode", m_icode_o, INOP);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Y86-64 pipeline memory stage, sitting directly downstream of the execute stage.
- Holds the M pipeline register and latches execute results: valE, valA, dstE, dstM, Cnd, icode, stat.
- Performs data-memory reads and writes over a request/grant/response handshake with variable latency; requests a pipeline stall while an access is outstanding.
- Presents m_* results to writeback and to the forwarding logic.

Parameters:
- MEM_BYTES, 8192, data memory size in bytes; legal 8-byte access iff addr <= MEM_BYTES-8.
- TIMEOUT, 255, maximum cycles to wait for dmem_rvalid_i before aborting with SADR.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- load_i  in  1  M-register load enable from pipeline control
- bubble_i  in  1  load a bubble (NOP) instead of e_* inputs; wins over load_i
- e_icode_i  in  4  instruction code
- e_stat_i  in  3  status from execute
- e_valE_i  in  64  ALU result
- e_valA_i  in  64  store data or pop/ret address
- e_dstE_i  in  4  E destination register
- e_dstM_i  in  4  M destination register
- e_Cnd_i  in  1  condition result
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  64  byte address
- dmem_wdata_o  out  64  write data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  access complete; read data valid
- dmem_err_i  in  1  qualifies rvalid; access faulted
- dmem_rdata_i  in  64  read data
- m_icode_o  out  4  icode
- m_stat_o  out  3  status
- m_valE_o  out  64  valE
- m_valM_o  out  64  loaded value
- m_dstE_o  out  4  dstE
- m_dstM_o  out  4  dstM
- m_Cnd_o  out  1  Cnd
- m_valid_o  out  1  m_* final this cycle
- mem_busy_o  out  1  stall request to pipeline control

Behaviour:
- Reset (async, rst_i=1):
  - M register = NOP: icode INOP, stat SAOK, dst RNONE, values 0, Cnd 0.
  - FSM = IDLE; counter 0.
  - dmem_req_o=0, mem_busy_o=0, m_valid_o=0, m_valM_o=0.
- Capture:
  - On a clock edge with (load_i|bubble_i) & ~mem_busy_o, the M register loads the e_* inputs, or a NOP if bubble_i.
  - Capture is ignored while mem_busy_o=1.
- Access classification of the captured instruction:
  - Read at valE: IMRMOVQ.
  - Read at valA: IPOPQ, IRET.
  - Write at valE: IRMMOVQ, IPUSHQ, ICALL; wdata = valA (valP for call).
  - Any other icode: no access.
- No access needed: covers non-memory icodes and any captured stat != SAOK. FSM goes to DONE at the capture edge; m_valid_o=1 the next cycle (latency 1). stat is passed through unchanged.
- Address fault: address > MEM_BYTES-8. FSM goes to DONE with stat=SADR; no request is issued.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE/DONE → REQ on capture of a legal memory access; otherwise → DONE on capture, else → IDLE.
  - REQ: dmem_req_o=1, with we/addr/wdata stable. Stays in REQ until dmem_gnt_i, then → WAIT and the counter clears.
  - WAIT: req=0; the counter increments each cycle.
    - On rvalid: valM = rdata (reads only); if err, stat=SADR; → DONE.
    - If the counter reaches TIMEOUT without rvalid: stat=SADR → DONE.
  - rvalid and gnt on the same cycle as REQ is accepted: REQ → DONE directly.
  - DONE: m_valid_o=1 for 1 cycle per instruction unless a new capture occurs.
- Busy and valid: mem_busy_o=1 in REQ and WAIT only; m_valid_o=0 in those states.
- Out-of-state responses: rvalid outside WAIT/REQ is ignored. This covers stale responses after a reset mid-access.
- Stores never modify m_valM_o; its previous value is held, and writeback ignores it when dstM=RNONE.
- m_dstE_o and m_Cnd_o are passed through from the M register unmodified.
- Reset mid-access drops dmem_req_o asynchronously.

Decomposition:
- Shared package (existing y86 defines): icode constants (INOP, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ), stat codes (SAOK, SADR, SINS, SHLT), RNONE.
- New package entries: FSM state encoding; 64-bit address/data width constant.
- Sub-module mem_access_fsm: FSM, handshake and timeout counter. The top level holds the M register and access classification.

Test Plan:
- Pass-through: capture IOPQ with valE=0x2A, dstE=3 → next cycle m_valid_o=1, m_valE_o=0x2A, m_dstE_o=3, no dmem_req_o, mem_busy_o never set.
- Load with latency: mrmovq valE=0x100; gnt after 2 cycles, rvalid 3 cycles later with rdata=0xDEADBEEF → dmem_addr_o=0x100, we=0; busy for 5 cycles; m_valM_o=0xDEADBEEF, stat SAOK; further load_i ignored while busy.
- Push write: pushq valE=0x1F0, valA=0x55, gnt and rvalid same cycle → we=1, addr=0x1F0, wdata=0x55, one REQ cycle, then DONE.
- Faults:
  - popq with valA=MEM_BYTES-4 → no request, m_stat_o=SADR.
  - mrmovq with rvalid+err → SADR.
  - mrmovq with no rvalid → SADR after exactly TIMEOUT WAIT cycles.
- Bubble and bad incoming stat: bubble_i=1 → INOP/RNONE; rmmovq with e_stat_i=SINS → no request, stat SINS preserved.
- Reset mid-access: rst_i asserted in WAIT → req/busy 0 immediately. A late rvalid after release is ignored and m_valM_o stays 0.
